alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Initiator side of the 8-bit ALU port (A, B, CTR in; O out). Accepts operation
//  commands over a valid/ready handshake and holds a small register file.
//  Reads operands from the register file and drives the ALU inputs.
//  Waits out the ALU's two register stages, then writes O back and reports it.
//  Sits between a command source (test sequencer/host) and one ALU instance.
// PARAMETERS
//  W     8  datapath width; must match ALU A/B/O width
//  NREG  4  register-file entries; index width log2(NREG)=2
//  LAT   2  ALU register stages from A/B/CTR to O (input reg + output reg)
// PORTS
//  ck         in   1   clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   controller can accept; handshake = cmd_valid & cmd_ready
//  cmd_ld     in   1   1: load immediate; 0: ALU operation
//  cmd_op     in   4   ALU control code, sent unchanged to alu_ctr
//  cmd_imm    in   W   immediate for loads
//  cmd_rd     in   2   destination register
//  cmd_rs1    in   2   source for alu_a
//  cmd_rs2    in   2   source for alu_b
//  alu_a      out  W   to ALU A (registered)
//  alu_b      out  W   to ALU B (registered)
//  alu_ctr    out  4   to ALU CTR (registered)
//  alu_o      in   W   from ALU O
//  res_valid  out  1   one-cycle pulse: res_data was just written to rf[cmd_rd]
//  res_data   out  W   value written
//  dbg_sel    in   2   register-file read select
//  dbg_data   out  W   rf[dbg_sel], combinational
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; cnt=0; rf[*]=0.
//   - alu_a=alu_b=0; alu_ctr=4'b0000; res_valid=0; res_data=0.
//   - The ALU has no reset. Its in-flight data is ignored because state is IDLE.
//  FSM states: IDLE, WAIT, WB. cmd_ready=1 only in IDLE.
//  IDLE, handshake with cmd_ld=1 (load):
//   - rf[cmd_rd]<=cmd_imm; res_data<=cmd_imm; res_valid<=1.
//   - Stay in IDLE, so back-to-back loads run one per cycle.
//  IDLE, handshake with cmd_ld=0 (ALU op):
//   - alu_a<=rf[rs1]; alu_b<=rf[rs2]; alu_ctr<=cmd_op.
//   - Latch rd; cnt<=0; go to WAIT.
//   - Operands are read as of this edge, including rs==rd.
//  WAIT: cnt increments every edge; when cnt==LAT-1, go to WB.
//  WB: on this edge rf[rd]<=alu_o; res_data<=alu_o; res_valid<=1; go to IDLE.
//  Timing, with accept edge = t:
//   - ALU captures its inputs at t+1; O is valid after t+2.
//   - Writeback edge is t+LAT+1 = t+3.
//   - res_valid is high in the cycle following t+3.
//   - Next accept is possible at edge t+4 (op throughput 1 per LAT+2 cycles).
//  alu_a/alu_b/alu_ctr hold their values until the next ALU-op accept.
//  res_valid is a single-cycle pulse and is cleared on every other edge.
//  cmd_valid during WAIT/WB: not accepted. The source must hold the command;
//   no loss and no duplication.
//  Opcodes 0010-0111: passed through unchanged. The ALU returns 0, so 0x00 is
//   written back. This is not an error.
//  All arithmetic is modulo 2^W (done in the ALU). No flags.
//  rst_n asserted in WAIT/WB: the pending writeback is dropped, no res_valid
//   is produced, and rf is cleared.
// TESTING (bench instantiates alu_ctrl + real ALU, ck shared)
//  1. Load r0=0x3C, r1=0xA5 on consecutive cycles -> two res_valid pulses with
//     data 0x3C then 0xA5; dbg r0/r1 match.
//  2. ADD r2=r0+r1 (op 0000) -> res_data=0xE1. res_valid is high exactly in the
//     cycle after edge t+3. cmd_ready is low for 3 cycles.
//  3. SUB r3=r0-r1 -> 0x97. XOR (1010) -> 0x99. NOT r1 (1011) -> 0x5A.
//     ROL r1 (1111) -> 0x4B. SHR r1 (1100) -> 0x52.
//  4. Hold cmd_valid high with 3 ops queued -> each accepted exactly once,
//     4 cycles apart; results in order.
//  5. ALU op r0=r0+r0 with r0=0x90 -> 0x20 (wrap). Op 0101 -> writes 0x00.
//  6. Pull rst_n low one cycle after an ALU accept -> outputs zero immediately,
//     no res_valid afterwards, all rf=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_ctrl.sv
// Command-driven controller for a two-stage 8-bit ALU: holds a small register
// file, issues ALU operations, waits out the ALU pipeline and writes results back.
module alu_ctrl #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned LAT  = 2,
  localparam int unsigned IW  = $clog2(NREG)
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_ld,
  input  logic [3:0]    cmd_op,
  input  logic [W-1:0]  cmd_imm,
  input  logic [IW-1:0] cmd_rd,
  input  logic [IW-1:0] cmd_rs1,
  input  logic [IW-1:0] cmd_rs2,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_ctr,
  input  logic [W-1:0]  alu_o,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  input  logic [IW-1:0] dbg_sel,
  output logic [W-1:0]  dbg_data
);

  localparam int unsigned CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WB} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  rd_q, rd_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [3:0]     ctr_q, ctr_d;
  logic           rv_q, rv_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic [W-1:0]   rf_q [NREG];
  logic [W-1:0]   rf_d [NREG];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    ctr_d   = ctr_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    rf_d    = rf_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_ld) begin
            rf_d[cmd_rd] = cmd_imm;
            rdata_d      = cmd_imm;
            rv_d         = 1'b1;
          end else begin
            a_d     = rf_q[cmd_rs1];
            b_d     = rf_q[cmd_rs2];
            ctr_d   = cmd_op;
            rd_d    = cmd_rd;
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      // O becomes valid LAT edges after the ALU sees its inputs
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LAT - 1)) state_d = S_WB;
      end
      S_WB: begin
        rf_d[rd_q] = alu_o;
        rdata_d    = alu_o;
        rv_d       = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_q   <= ctr_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      rf_q    <= rf_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctr   = ctr_q;
  assign res_valid = rv_q;
  assign res_data  = rdata_q;
  assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl driving a behavioural two-stage ALU; results are checked
// against a transaction-level register-file model.
module tb_alu_ctrl;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_ld;
  logic [3:0] cmd_op;
  logic [7:0] cmd_imm;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_ctr;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_acc = -100;
  logic [7:0] ref_rf [4];

  always #5 ck = ~ck;

  alu_ctrl #(.W(8), .NREG(4), .LAT(2)) dut (
    .ck(ck), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
    .res_valid(res_valid), .res_data(res_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    case (op)
      4'b0000: return 8'((x + y) % 256);
      4'b0001: return 8'((x - y + 256) % 256);
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b1011: return 8'(255 - x);
      4'b1100: return 8'(x / 2);
      4'b1101: return 8'((x * 2) % 256);
      4'b1110: return 8'(x / 2 + (x % 2) * 128);
      4'b1111: return 8'((x * 2) % 256 + x / 128);
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ALU: input register stage then output register stage, no reset
  logic [7:0] ar, br;
  logic [3:0] cr;
  logic [7:0] o_r;
  always @(posedge ck) begin
    ar  <= alu_a;
    br  <= alu_b;
    cr  <= alu_ctr;
    o_r <= alu_f(cr, ar, br);
  end
  assign alu_o = o_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ck);
    #1;
    cyc++;
  endtask

  task automatic check_dbg(input logic [1:0] r);
    dbg_sel = r;
    #1;
    check("dbg", dbg_data, ref_rf[r]);
  endtask

  task automatic issue(input bit ld, input logic [3:0] op, input logic [7:0] imm,
                       input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                       input bit hold, input bit chk_gap);
    int waited = 0;
    logic [7:0] exp;
    cmd_ld = ld; cmd_op = op; cmd_imm = imm;
    cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    step();
    if (chk_gap) check("accept_gap", cyc - last_acc, 4);
    last_acc = cyc;
    if (!hold) cmd_valid = 1'b0;
    if (ld) begin
      ref_rf[rd] = imm;
      check("ld_valid", res_valid, 1);
      check("ld_data", res_data, imm);
    end else begin
      exp = alu_f(op, ref_rf[rs1], ref_rf[rs2]);
      check("alu_a", alu_a, ref_rf[rs1]);
      check("alu_b", alu_b, ref_rf[rs2]);
      check("alu_ctr", alu_ctr, op);
      check("wait_ready", cmd_ready, 0);
      check("wait_valid", res_valid, 0);
      step();
      check("wait_ready1", cmd_ready, 0);
      check("wait_valid1", res_valid, 0);
      step();
      check("wb_ready", cmd_ready, 0);
      check("wb_valid", res_valid, 0);
      step();
      check("op_valid", res_valid, 1);
      check("op_data", res_data, exp);
      check("op_ready", cmd_ready, 1);
      ref_rf[rd] = exp;
    end
    check_dbg(rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [5];
    ops = '{4'b0001, 4'b1010, 4'b1011, 4'b1111, 4'b1100};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0; cmd_imm = '0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; dbg_sel = '0;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    step(); step();
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) check_dbg(2'(i));
    rst_n = 1'b1;
    step();

    // Directed loads and operations
    issue(1, 4'h0, 8'h3C, 2'd0, 2'd0, 2'd0, 0, 0);
    issue(1, 4'h0, 8'hA5, 2'd1, 2'd0, 2'd0, 0, 0);
    check("ld_b2b_gap", cyc - last_acc, 0);
    check_dbg(2'd0);
    issue(0, 4'b0000, 8'h00, 2'd2, 2'd0, 2'd1, 0, 0);
    check("add_e1", ref_rf[2], 8'hE1);
    for (int i = 0; i < 5; i++) issue(0, ops[i], 8'h00, 2'd3, (i == 0) ? 2'd0 : 2'd1,
                                      (i == 0) ? 2'd1 : 2'd0, 0, 0);

    // Held valid: three queued ops, each accepted once, 4 cycles apart
    issue(0, 4'b0000, 8'h00, 2'd2, 2'd0, 2'd1, 1, 0);
    issue(0, 4'b0001, 8'h00, 2'd3, 2'd2, 2'd0, 1, 1);
    issue(0, 4'b1001, 8'h00, 2'd2, 2'd3, 2'd1, 0, 1);
    step();
    check("no_dup_valid", res_valid, 0);

    // Wrap and pass-through opcodes
    issue(1, 4'h0, 8'h90, 2'd0, 2'd0, 2'd0, 0, 0);
    issue(0, 4'b0000, 8'h00, 2'd0, 2'd0, 2'd0, 0, 0);
    check("wrap_20", ref_rf[0], 8'h20);
    issue(0, 4'b0101, 8'h00, 2'd1, 2'd0, 2'd2, 0, 0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      issue($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 0, 0);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset one cycle after an ALU accept drops the pending writeback
    issue(1, 4'h0, 8'h11, 2'd1, 2'd0, 2'd0, 0, 0);
    cmd_ld = 1'b0; cmd_op = 4'b0000; cmd_rd = 2'd2; cmd_rs1 = 2'd1; cmd_rs2 = 2'd1;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("pre_rst_alu_a", alu_a, ref_rf[1]);
    step();
    rst_n = 1'b0;
    #1;
    check("async_alu_a", alu_a, 0);
    check("async_alu_b", alu_b, 0);
    check("async_res_data", res_data, 0);
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_valid", res_valid, 0);
    end
    check("post_rst_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) check_dbg(2'(i));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
